// File: rtl/bcd_engine_arbiter.sv
// Round-robin arbiter that lets NUM_CH binary channels share one binary_to_bcd engine.
// It keeps a per-channel registered BCD result and re-converts a channel only when its input changes.
module bcd_engine_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 4,
  parameter int TIMEOUT        = 64
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_CH*INPUT_WIDTH-1:0]    i_values,
  output logic [INPUT_WIDTH-1:0]           o_engine_bin,
  output logic                             o_engine_start,
  input  logic [4*DECIMAL_DIGITS-1:0]      i_engine_bcd,
  input  logic                             i_engine_dv,
  output logic [NUM_CH*4*DECIMAL_DIGITS-1:0] o_bcd,
  output logic [NUM_CH-1:0]                o_bcd_valid,
  output logic [NUM_CH-1:0]                o_update,
  output logic                             o_busy,
  output logic                             o_timeout_err
);

  localparam int BW   = 4 * DECIMAL_DIGITS;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] shadow_q [NUM_CH];
  logic [NUM_CH-1:0]      pending;
  logic [CH_W-1:0]        last_grant_q, grant_q, pick;
  logic                   pick_vld;
  logic [TW-1:0]          wait_cnt_q;
  logic                   accept, expire;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      pending[c] = (i_values[c*INPUT_WIDTH +: INPUT_WIDTH] != shadow_q[c]);
  end

  // Search starts one past the last served channel so every channel gets a fair turn.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_CH;
      if (!pick_vld && pending[idx]) begin
        pick     = CH_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // The first WAIT cycle never accepts: dv may still be high from the previous result.
  assign accept = (state_q == S_WAIT) && (wait_cnt_q != '0) && i_engine_dv;
  assign expire = (state_q == S_WAIT) && !accept && (wait_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_vld) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (accept || expire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_engine_start = (state_q == S_START);
    o_busy         = (state_q != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_engine_bin  <= '0;
      o_bcd         <= '0;
      o_bcd_valid   <= '0;
      o_update      <= '0;
      o_timeout_err <= 1'b0;
      wait_cnt_q    <= '0;
      grant_q       <= '0;
      last_grant_q  <= CH_W'(NUM_CH - 1);
      for (int c = 0; c < NUM_CH; c++)
        shadow_q[c] <= ~i_values[c*INPUT_WIDTH +: INPUT_WIDTH];
    end else begin
      o_update <= '0;
      if (state_q == S_IDLE && pick_vld) begin
        grant_q        <= pick;
        o_engine_bin   <= i_values[int'(pick)*INPUT_WIDTH +: INPUT_WIDTH];
        shadow_q[pick] <= i_values[int'(pick)*INPUT_WIDTH +: INPUT_WIDTH];
      end
      if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
      else                   wait_cnt_q <= '0;
      if (accept) begin
        o_bcd[int'(grant_q)*BW +: BW] <= i_engine_bcd;
        o_bcd_valid[grant_q]          <= 1'b1;
        o_update[grant_q]             <= 1'b1;
        last_grant_q                  <= grant_q;
      end
      // Inverting the shadow keeps the abandoned channel pending for a retry.
      if (expire) begin
        o_timeout_err     <= 1'b1;
        shadow_q[grant_q] <= ~i_values[int'(grant_q)*INPUT_WIDTH +: INPUT_WIDTH];
        last_grant_q      <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_bcd_engine_arbiter.sv
// Bench for bcd_engine_arbiter: a behavioural BCD engine plus a scoreboard of hand-computed results.
module tb_bcd_engine_arbiter;

  localparam int NCH = 4;
  localparam int IW  = 16;
  localparam int DD  = 4;
  localparam int TO  = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [IW-1:0]       v [NCH];
  logic [NCH*IW-1:0]   values;
  logic [IW-1:0]       eng_bin;
  logic                eng_start;
  logic [4*DD-1:0]     e_bcd = '0;
  logic                e_dv = 1'b0;
  logic [NCH*4*DD-1:0] bcd;
  logic [NCH-1:0]      bcd_valid, upd;
  logic                busy, terr;

  typedef struct {int ch; logic [15:0] bcd;} exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  int  lat = 20;
  bit  dead = 0;
  bit  stale = 0;
  logic [IW-1:0] e_bin = '0;
  int  e_cnt = 0;
  bit  e_act = 0;
  logic [NCH-1:0] prev_upd = '0;

  assign values = {v[3], v[2], v[1], v[0]};

  always #5 clk = ~clk;

  bcd_engine_arbiter #(.NUM_CH(NCH), .INPUT_WIDTH(IW), .DECIMAL_DIGITS(DD), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_values(values),
    .o_engine_bin(eng_bin), .o_engine_start(eng_start),
    .i_engine_bcd(e_bcd), .i_engine_dv(e_dv),
    .o_bcd(bcd), .o_bcd_valid(bcd_valid), .o_update(upd),
    .o_busy(busy), .o_timeout_err(terr)
  );

  function automatic logic [15:0] engine_convert(input logic [IW-1:0] b);
    logic [15:0] r;
    int x;
    x = int'(b);
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Engine: result valid is a level held until the next start; stale mode drops it one cycle late.
  always @(posedge clk) begin
    if (eng_start) begin
      e_bin <= eng_bin;
      e_cnt <= lat;
      e_act <= !dead;
      if (!stale) e_dv <= 1'b0;
    end else if (e_act) begin
      if (e_cnt == 1) begin
        e_dv  <= 1'b1;
        e_bcd <= engine_convert(e_bin);
        e_act <= 1'b0;
      end else begin
        e_cnt <= e_cnt - 1;
        e_dv  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_upd = '0;
    end else begin
      if (eng_start) begin
        vectors++;
        if (!busy) begin
          miscompares++;
          $display("FAIL start_outside_busy: busy=%0b required 1", busy);
        end
      end
      if (upd != '0) begin
        vectors++;
        if (prev_upd != '0 || !$onehot(upd)) begin
          miscompares++;
          $display("FAIL update_pulse: upd=%b prev=%b required single one-cycle bit", upd, prev_upd);
        end else if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_update: upd=%b with no expected result", upd);
        end else begin
          exp_t e;
          int ch;
          e = q.pop_front();
          ch = 0;
          for (int i = 0; i < NCH; i++) if (upd[i]) ch = i;
          if (ch != e.ch || bcd[ch*16 +: 16] !== e.bcd || !bcd_valid[ch]) begin
            miscompares++;
            $display("FAIL result: ch=%0d bcd=%h valid=%b required ch=%0d bcd=%h valid=1",
                     ch, bcd[ch*16 +: 16], bcd_valid[ch], e.ch, e.bcd);
          end
        end
      end
      prev_upd = upd;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic push(input int ch, input logic [15:0] b);
    exp_t e;
    e.ch = ch;
    e.bcd = b;
    q.push_back(e);
  endtask

  task automatic drain(input string nm, input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_%s: %0d results outstanding, required 0", nm, q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while (!eng_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!eng_start) begin
      miscompares++;
      $display("FAIL start_%s: no start pulse, got 0 required 1", nm);
    end
  endtask

  initial begin
    int n;
    v[0] = 16'd1234; v[1] = 16'd9; v[2] = 16'd0; v[3] = 16'd65535;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_bcd", 64'(bcd), 64'h0);
    chk("reset_flags", {58'h0, bcd_valid, busy, terr}, 64'h0);
    chk("reset_upd_start_bin", {43'h0, upd, eng_start, eng_bin}, 64'h0);

    // Post-reset sweep, channel order 0..3, 65535 truncated to four digits.
    push(0, 16'h1234); push(1, 16'h0009); push(2, 16'h0000); push(3, 16'h5535);
    rst = 1'b0;
    drain("reset_sweep", 400);
    chk("sweep_valid", 64'(bcd_valid), 64'hf);
    chk("sweep_bcd", 64'(bcd), 64'h5535_0000_0009_1234);

    // Serve channel 2 so the last grant is 2, then change 1 and 3 together.
    v[2] = 16'd42; push(2, 16'h0042);
    drain("ch2", 200);
    v[1] = 16'd77; v[3] = 16'd300;
    push(3, 16'h0300); push(1, 16'h0077);
    drain("rr_order", 300);

    // Own input changes while in flight: old value stored, then re-converted.
    v[2] = 16'd5;
    push(2, 16'h0005); push(2, 16'h0006);
    wait_start("inflight");
    repeat (3) @(negedge clk);
    v[2] = 16'd6;
    drain("inflight", 300);

    // Dead engine: exactly TO WAIT cycles, then a retry once it recovers.
    chk("err_before_timeout", 64'(terr), 64'h0);
    dead = 1;
    v[0] = 16'd777;
    wait_start("timeout");
    @(negedge clk);
    n = 0;
    while (busy && n < 4 * TO) begin
      n++;
      @(negedge clk);
    end
    chk("wait_cycles", 64'(n), 64'(TO));
    chk("timeout_err", 64'(terr), 64'h1);
    chk("timeout_bcd_kept", 64'(bcd[15:0]), 64'h1234);
    dead = 0;
    push(0, 16'h0777);
    drain("retry", 300);

    // Stale dv still high from 0777 result during the first WAIT cycle.
    stale = 1; lat = 5;
    v[1] = 16'd4321;
    push(1, 16'h4321);
    drain("stale_dv", 200);
    stale = 0; lat = 20;

    // Reset in WAIT; the late dv lands while in reset or idle.
    v[3] = 16'd12;
    wait_start("mid_reset");
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_bcd", 64'(bcd), 64'h0);
    chk("midreset_flags", {58'h0, bcd_valid, busy, terr}, 64'h0);
    chk("midreset_upd_start_bin", {43'h0, upd, eng_start, eng_bin}, 64'h0);
    repeat (5) @(negedge clk);
    push(0, 16'h0777); push(1, 16'h4321); push(2, 16'h0006); push(3, 16'h0012);
    rst = 1'b0;
    drain("reconvert", 400);
    chk("final_valid", 64'(bcd_valid), 64'hf);
    chk("final_bcd", 64'(bcd), 64'h0012_0006_4321_0777);
    chk("final_err", 64'(terr), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
